hazard_ctrl: RTL and testbench

- Pipeline controller for the OTTER 5-stage pipeline; sits beside the Fetch/Decode/Execute/Memory registers and sequences them.
- Detects load-use hazards and drives stall and bubble controls.
- Flushes the Fetch and Decode registers on a taken branch or jump, and freezes the pipeline while data memory is busy.
- Generates operand-forwarding selects for the Execute stage and keeps saturating stall/flush event counters.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd.sv | 30 +++
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
// State encoding, forwarding-select codes and the canonical NOP.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        FREEZE   = 2'd3
    } state_e;

    localparam logic [1:0]  FWD_DR  = 2'b00;
    localparam logic [1:0]  FWD_MEM = 2'b01;
    localparam logic [1:0]  FWD_WB  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Operand forwarding compare for one Execute-stage source register.
// Memory-stage ALU results win over Writeback; x0 is never forwarded.
module fwd_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_we_i,
    input  logic                  mem_load_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_we_i,
    output logic [1:0]            sel_o
);
    import hazard_pkg::*;

    logic rs_nz;

    assign rs_nz = (rs_i != '0);

    // Pick the youngest producer of rs; load data is not ready in Memory.
    always_comb begin
        sel_o = FWD_DR;
        if (rs_nz && mem_we_i && !mem_load_i && (mem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (rs_nz && wb_we_i && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// OTTER 5-stage pipeline sequencer: load-use stalls, redirect flushes,
// data-memory freezes, forwarding selects and saturating event counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  REG_CLOCK,
    input  logic                  REG_RESET,
    input  logic [REG_ADDR_W-1:0] DEC_RS1,
    input  logic [REG_ADDR_W-1:0] DEC_RS2,
    input  logic                  DEC_USES_RS2,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_REGWRITE,
    input  logic                  EX_MEMREAD,
    input  logic [REG_ADDR_W-1:0] MEM_RD,
    input  logic                  MEM_REGWRITE,
    input  logic                  EX_REDIRECT,
    input  logic                  DMEM_BUSY,
    output logic                  PC_WRITE,
    output logic                  FR_WRITE,
    output logic                  DR_WRITE,
    output logic                  FR_FLUSH,
    output logic                  DR_FLUSH,
    output logic [1:0]            FWD_A_SEL,
    output logic [1:0]            FWD_B_SEL,
    output logic [CNT_W-1:0]      STALL_COUNT,
    output logic [CNT_W-1:0]      FLUSH_COUNT
);
    import hazard_pkg::*;

    localparam logic [1:0]       FC_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e                state_q, state_d, eff_st;
    logic [1:0]            fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [CNT_W-1:0]      flush_q, flush_d;
    logic                  lu;
    logic                  pcw, frw, drw, frf, drf;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q;
    logic                  mem_load_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_we_q;

    assign lu = EX_MEMREAD & EX_REGWRITE & (EX_RD != '0)
              & ((EX_RD == DEC_RS1)
              | (DEC_USES_RS2 & (EX_RD == DEC_RS2)));

    // Leaving FREEZE behaves like the state it resumes into.
    always_comb begin
        eff_st = state_q;
        if ((state_q == FREEZE) && !DMEM_BUSY) begin
            eff_st = (fcnt_q != 2'd0) ? FLUSH : RUN;
        end
    end

    // Next state, counters and raw pipeline controls.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        stall_d = stall_q;
        flush_d = flush_q;
        pcw     = 1'b1;
        frw     = 1'b1;
        drw     = 1'b1;
        frf     = 1'b0;
        drf     = 1'b0;
        if (DMEM_BUSY) begin
            pcw     = 1'b0;
            frw     = 1'b0;
            drw     = 1'b0;
            state_d = FREEZE;
        end else begin
            state_d = RUN;
            unique case (eff_st)
                FLUSH: begin
                    frf    = 1'b1;
                    drf    = 1'b1;
                    fcnt_d = fcnt_q - 2'd1;
                    if (fcnt_q > 2'd1) begin
                        state_d = FLUSH;
                    end
                end
                LD_STALL: begin
                    state_d = RUN;
                end
                default: begin
                    if (EX_REDIRECT) begin
                        frf = 1'b1;
                        drf = 1'b1;
                        if (flush_q != CNT_MAX) begin
                            flush_d = flush_q + CNT_ONE;
                        end
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FC_RELOAD;
                        end
                    end else if (lu) begin
                        pcw     = 1'b0;
                        frw     = 1'b0;
                        drf     = 1'b1;
                        state_d = LD_STALL;
                        if (stall_q != CNT_MAX) begin
                            stall_d = stall_q + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state, flush countdown and event counters.
    always_ff @(posedge REG_CLOCK or negedge REG_RESET) begin
        if (!REG_RESET) begin
            state_q <= RUN;
            fcnt_q  <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Shadow of Execute sources and downstream writers for forwarding.
    always_ff @(posedge REG_CLOCK or negedge REG_RESET) begin
        if (!REG_RESET) begin
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            mem_load_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
        end else if (drw) begin
            ex_rs1_q   <= drf ? '0 : DEC_RS1;
            ex_rs2_q   <= drf ? '0 : DEC_RS2;
            mem_load_q <= EX_MEMREAD & EX_REGWRITE;
            wb_rd_q    <= MEM_RD;
            wb_we_q    <= MEM_REGWRITE;
        end
    end

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i       (ex_rs1_q),
        .mem_rd_i   (MEM_RD),
        .mem_we_i   (MEM_REGWRITE),
        .mem_load_i (mem_load_q),
        .wb_rd_i    (wb_rd_q),
        .wb_we_i    (wb_we_q),
        .sel_o      (FWD_A_SEL)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i       (ex_rs2_q),
        .mem_rd_i   (MEM_RD),
        .mem_we_i   (MEM_REGWRITE),
        .mem_load_i (mem_load_q),
        .wb_rd_i    (wb_rd_q),
        .wb_we_i    (wb_we_q),
        .sel_o      (FWD_B_SEL)
    );

    assign PC_WRITE    = REG_RESET & pcw;
    assign FR_WRITE    = REG_RESET & frw;
    assign DR_WRITE    = REG_RESET & drw;
    assign FR_FLUSH    = ~REG_RESET | frf;
    assign DR_FLUSH    = ~REG_RESET | drf;
    assign STALL_COUNT = stall_q;
    assign FLUSH_COUNT = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model.
// A second narrow-counter instance exercises counter saturation.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, ex_rd = '0, mem_rd = '0;
    logic       uses2 = 1'b0, ex_we = 1'b0, ex_mr = 1'b0, mem_we = 1'b0;
    logic       redir = 1'b0, busy = 1'b0;

    logic        pcw, frw, drw, frf, drf;
    logic [1:0]  fa, fb;
    logic [15:0] scnt, fcnt;

    logic        s_pcw, s_frw, s_drw, s_frf, s_drf;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_scnt, s_fcnt;

    int n_chk = 0;
    int n_fail = 0;

    int m_left, m_stalled, m_stall, m_flush;
    int m_rs1, m_rs2, m_mload, m_wbrd, m_wbwe;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .REG_CLOCK(clk), .REG_RESET(rst_n),
        .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2), .DEC_USES_RS2(uses2),
        .EX_RD(ex_rd), .EX_REGWRITE(ex_we), .EX_MEMREAD(ex_mr),
        .MEM_RD(mem_rd), .MEM_REGWRITE(mem_we),
        .EX_REDIRECT(redir), .DMEM_BUSY(busy),
        .PC_WRITE(pcw), .FR_WRITE(frw), .DR_WRITE(drw),
        .FR_FLUSH(frf), .DR_FLUSH(drf),
        .FWD_A_SEL(fa), .FWD_B_SEL(fb),
        .STALL_COUNT(scnt), .FLUSH_COUNT(fcnt)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .CNT_W(2)) u_sat (
        .REG_CLOCK(clk), .REG_RESET(rst_n),
        .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2), .DEC_USES_RS2(uses2),
        .EX_RD(ex_rd), .EX_REGWRITE(ex_we), .EX_MEMREAD(ex_mr),
        .MEM_RD(mem_rd), .MEM_REGWRITE(mem_we),
        .EX_REDIRECT(redir), .DMEM_BUSY(busy),
        .PC_WRITE(s_pcw), .FR_WRITE(s_frw), .DR_WRITE(s_drw),
        .FR_FLUSH(s_frf), .DR_FLUSH(s_drf),
        .FWD_A_SEL(s_fa), .FWD_B_SEL(s_fb),
        .STALL_COUNT(s_scnt), .FLUSH_COUNT(s_fcnt)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        return ex_mr && ex_we && ex_rd != 0 &&
               (ex_rd == dec_rs1 || (uses2 && ex_rd == dec_rs2));
    endfunction

    // Controls required this cycle, from the spec's priority rules.
    function automatic void model_out(output bit p, output bit f,
                                      output bit d, output bit ff,
                                      output bit df);
        p = 1; f = 1; d = 1; ff = 0; df = 0;
        if (busy) begin
            p = 0; f = 0; d = 0;
        end else if (m_left > 0) begin
            ff = 1; df = 1;
        end else if (m_stalled != 0) begin
            p = 1;
        end else if (redir) begin
            ff = 1; df = 1;
        end else if (load_use()) begin
            p = 0; f = 0; df = 1;
        end
    endfunction

    function automatic int fsel(int rs);
        if (rs != 0 && mem_we && int'(mem_rd) == rs && m_mload == 0)
            return 1;
        if (rs != 0 && m_wbwe != 0 && m_wbrd == rs)
            return 2;
        return 0;
    endfunction

    // Reference pipeline bookkeeping, advanced on every clock.
    always @(posedge clk or negedge rst_n) begin
        bit p, f, d, ff, df;
        if (!rst_n) begin
            m_left = 0; m_stalled = 0; m_stall = 0; m_flush = 0;
            m_rs1 = 0; m_rs2 = 0; m_mload = 0; m_wbrd = 0; m_wbwe = 0;
        end else begin
            model_out(p, f, d, ff, df);
            if (busy) begin
                m_stalled = 0;
            end else begin
                if (m_left > 0) begin
                    m_left = m_left - 1;
                end else if (m_stalled != 0) begin
                    m_stalled = 0;
                end else if (redir) begin
                    if (m_flush < 65535) m_flush = m_flush + 1;
                    m_left = FC - 1;
                end else if (load_use()) begin
                    if (m_stall < 65535) m_stall = m_stall + 1;
                    m_stalled = 1;
                end
                m_rs1   = df ? 0 : int'(dec_rs1);
                m_rs2   = df ? 0 : int'(dec_rs2);
                m_mload = (ex_mr && ex_we) ? 1 : 0;
                m_wbrd  = int'(mem_rd);
                m_wbwe  = mem_we ? 1 : 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit p, f, d, ff, df;
        if (!rst_n) begin
            chk("rst_pcw", 32'(pcw), 0);
            chk("rst_frw", 32'(frw), 0);
            chk("rst_drw", 32'(drw), 0);
            chk("rst_frf", 32'(frf), 1);
            chk("rst_drf", 32'(drf), 1);
            chk("rst_fa", 32'(fa), 0);
            chk("rst_fb", 32'(fb), 0);
            chk("rst_scnt", 32'(scnt), 0);
            chk("rst_fcnt", 32'(fcnt), 0);
        end else begin
            model_out(p, f, d, ff, df);
            chk("pc_write", 32'(pcw), 32'(p));
            chk("fr_write", 32'(frw), 32'(f));
            chk("dr_write", 32'(drw), 32'(d));
            chk("fr_flush", 32'(frf), 32'(ff));
            chk("dr_flush", 32'(drf), 32'(df));
            chk("fwd_a", 32'(fa), 32'(fsel(m_rs1)));
            chk("fwd_b", 32'(fb), 32'(fsel(m_rs2)));
            chk("stall_cnt", 32'(scnt), 32'(m_stall));
            chk("flush_cnt", 32'(fcnt), 32'(m_flush));
        end
    end

    task automatic drive(bit b, bit r, bit mr, bit we, int erd,
                         int r1, int r2, bit u2, int mrd, bit mwe);
        busy = b; redir = r; ex_mr = mr; ex_we = we; ex_rd = 5'(erd);
        dec_rs1 = 5'(r1); dec_rs2 = 5'(r2); uses2 = u2;
        mem_rd = 5'(mrd); mem_we = mwe;
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_fr_flush", 32'(frf), 1);
        chk("reset_pc_write", 32'(pcw), 0);
        nxt();
        rst_n = 1'b1;
        idle();

        // lw x5 in Execute, Decode reads x5
        drive(0, 0, 1, 1, 5, 5, 0, 0, 0, 0);
        chk("lu_pcw", 32'(pcw), 0);
        chk("lu_frw", 32'(frw), 0);
        chk("lu_drf", 32'(drf), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 5, 0, 0, 5, 1);
        chk("lu_after_pcw", 32'(pcw), 1);
        chk("lu_after_drf", 32'(drf), 0);
        chk("lu_scnt", 32'(scnt), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        chk("lu_fwd_wb", 32'(fa), 2);
        nxt();
        idle();

        // rs2 dependence only counts when rs2 is used; x0 never stalls
        drive(0, 0, 1, 1, 6, 1, 6, 0, 0, 0);
        chk("rs2_unused", 32'(pcw), 1);
        nxt();
        drive(0, 0, 1, 1, 6, 1, 6, 1, 0, 0);
        chk("rs2_used", 32'(pcw), 0);
        nxt();
        idle();
        drive(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        chk("x0_nostall", 32'(pcw), 1);
        nxt();
        idle();

        // taken branch, two flush cycles
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_frf0", 32'(frf), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_frf1", 32'(frf), 1);
        chk("br_drf1", 32'(drf), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_frf2", 32'(frf), 0);
        chk("br_fcnt", 32'(fcnt), 1);
        nxt();

        // data memory busy for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("busy_pcw", 32'(pcw), 0);
            nxt();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_resume", 32'(pcw), 1);
        nxt();

        // freeze in the middle of a flush keeps the remaining flush
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("fl_frz_frf", 32'(frf), 0);
            nxt();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_resume_frf", 32'(frf), 1);
        nxt();
        idle();

        // busy with a redirect held until the unfreeze cycle
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_busy_frf", 32'(frf), 0);
        chk("br_busy_pcw", 32'(pcw), 0);
        nxt();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_unfrz_frf", 32'(frf), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_unfrz_fcnt", 32'(fcnt), 3);
        nxt();
        idle();

        // Memory and Writeback both write x7: Memory wins
        drive(0, 0, 0, 0, 0, 7, 7, 1, 0, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 7, 7, 1, 7, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
        chk("fwd_mem_a", 32'(fa), 1);
        chk("fwd_mem_b", 32'(fb), 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("fwd_x0", 32'(fa), 0);
        nxt();
        idle();

        // asynchronous reset during the load-use stall
        drive(0, 0, 1, 1, 9, 9, 0, 0, 0, 0);
        nxt();
        ex_mr = 0; ex_we = 0; ex_rd = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pcw", 32'(pcw), 0);
        chk("mid_rst_frf", 32'(frf), 1);
        chk("mid_rst_scnt", 32'(scnt), 0);
        nxt();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pcw", 32'(pcw), 1);
        chk("post_rst_frf", 32'(frf), 0);
        nxt();

        // five stalls and five redirects against a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 4, 4, 0, 0, 0, 0);
            nxt();
            idle();
            idle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            nxt();
            idle();
            idle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_scnt", 32'(s_scnt), 3);
        chk("sat_fcnt", 32'(s_fcnt), 3);
        chk("wide_scnt", 32'(scnt), 5);
        chk("wide_fcnt", 32'(fcnt), 5);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
